// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/WB)
// with a bounded fetch wait, ebreak halt and a sticky error state.
module exec_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_inst,
  output logic [31:0] inst,
  input  logic        reg_write_in,
  output logic        reg_wen,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     cur_state;
  logic [7:0] wait_cnt;

  // Sequencer state, program counter, retire counter and fetch wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IDLE;
      pc        <= RESET_PC;
      instret   <= '0;
      inst      <= '0;
      wait_cnt  <= '0;
    end else begin
      case (cur_state)
        S_IDLE: begin
          if (start) begin
            cur_state <= S_FETCH;
            wait_cnt  <= '0;
          end
        end
        S_FETCH: begin
          if (ifu_valid) begin
            inst      <= ifu_inst;
            cur_state <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            cur_state <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (inst == EBREAK) begin
            instret   <= instret + 32'd1;
            cur_state <= S_HALT;
          end else begin
            cur_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          cur_state <= S_WB;
        end
        S_WB: begin
          pc        <= pc + 32'd4;
          instret   <= instret + 32'd1;
          wait_cnt  <= '0;
          cur_state <= S_FETCH;
        end
        default: begin
          cur_state <= cur_state;
        end
      endcase
    end
  end

  // Outputs decoded from the current state; a write in flight is dropped while rst is high.
  always_comb begin
    state    = cur_state;
    ifu_req  = (cur_state == S_FETCH);
    ifu_addr = pc;
    reg_wen  = (cur_state == S_WB) && reg_write_in && !rst;
    retire   = (cur_state == S_WB) || ((cur_state == S_DECODE) && (inst == EBREAK));
    halted   = (cur_state == S_HALT);
    err      = (cur_state == S_ERROR);
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h8000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, 16, maximum FETCH cycles without ifu_valid before ERROR (legal range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  leaves IDLE when sampled high.
REQ-006 SHALL have port ifu_req  output  1  instruction fetch request.
REQ-007 SHALL have port ifu_addr  output  32  fetch address, always equal to pc.
REQ-008 SHALL have port ifu_valid  input  1  fetched word valid this cycle.
REQ-009 SHALL have port ifu_inst  input  32  fetched instruction word.
REQ-010 SHALL have port inst  output  32  latched instruction driven to the decoder.
REQ-011 SHALL have port reg_write_in  input  1  register-write request from the control unit.
REQ-012 SHALL have port reg_wen  output  1  gated register-file write enable.
REQ-013 SHALL have port pc  output  32  program counter.
REQ-014 SHALL have port retire  output  1  one-cycle pulse per retired instruction.
REQ-015 SHALL have port instret  output  32  retired-instruction counter.
REQ-016 SHALL have port halted  output  1  high in HALT.
REQ-017 SHALL have port err  output  1  high in ERROR.
REQ-018 SHALL have port state  output  3  encoding IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5, ERROR=6.

Function
REQ-019 IDLE SHALL drive ifu_req=0 and go to FETCH on the next edge when start=1, otherwise remain in IDLE.
REQ-020 FETCH SHALL drive ifu_req=1 and ifu_addr=pc, and on ifu_valid=1 SHALL latch ifu_inst into inst and go to DECODE.
REQ-021 FETCH wait counter SHALL clear on FETCH entry and increment each FETCH cycle with ifu_valid=0.
REQ-022 When the counter equals TIMEOUT-1 and ifu_valid=0, the next state SHALL be ERROR; ifu_valid on that same cycle SHALL still be accepted.
REQ-023 ifu_valid and ifu_inst SHALL be ignored outside FETCH; inst SHALL hold its value until the next accepted fetch.
REQ-024 DECODE with inst == 32'h0010_0073 (ebreak) SHALL go to HALT, pulse retire, and increment instret, leaving pc unchanged.
REQ-025 DECODE with any other inst SHALL go to EXEC.
REQ-026 EXEC SHALL last exactly one cycle and then go to WB.
REQ-027 WB SHALL drive reg_wen=reg_write_in and pulse retire=1.
REQ-028 The WB exit edge SHALL load pc with pc+4 modulo 2^32, increment instret modulo 2^32, and go to FETCH.
REQ-029 reg_wen SHALL be 0 in every state other than WB.
REQ-030 Latency: with ifu_valid high on the first FETCH cycle, one non-ebreak instruction SHALL take 4 cycles (FETCH, DECODE, EXEC, WB).
REQ-031 HALT and ERROR SHALL be sticky until rst, with ifu_req=0, reg_wen=0, retire=0, and pc/instret frozen; start SHALL be ignored in both.
REQ-032 start SHALL be ignored in all states except IDLE.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, instret=0, inst=0, and clear the wait counter.
REQ-034 Outputs after reset SHALL be ifu_req=0, reg_wen=0, retire=0, halted=0, err=0.
REQ-035 rst SHALL override every state, including mid-instruction, HALT and ERROR, and SHALL discard any in-flight write with no reg_wen pulse.

Verification
REQ-036 Bench SHALL cover: reset, start=1, ifu_valid=1 immediately with ifu_inst=32'h0050_0093, reg_write_in=1 -> inst=32'h0050_0093, reg_wen and retire pulse on 4th cycle after FETCH entry, then pc=32'h8000_0004, instret=1.
REQ-037 Bench SHALL cover: ifu_valid delayed 3 cycles -> FETCH held 4 cycles, ifu_req=1 and ifu_addr=32'h8000_0000 constant, then normal retire.
REQ-038 Bench SHALL cover: ifu_inst=32'h0010_0073 -> halted=1 two cycles after acceptance, pc stays 32'h8000_0000, instret=1, ifu_req=0 thereafter despite start pulses.
REQ-039 Bench SHALL cover: ifu_valid held 0 -> err=1 and state=6 after exactly 16 FETCH cycles; a second run with ifu_valid on the 16th cycle -> DECODE, no error.
REQ-040 Bench SHALL cover: rst asserted during EXEC with reg_write_in=1 -> no reg_wen pulse, next cycle state=0, pc=RESET_PC, instret=0.
REQ-041 Bench SHALL cover: RESET_PC=32'hFFFF_FFFC, one non-ebreak instruction retired -> pc=32'h0000_0000, instret=1.
